// File: rtl/qbus_slave.sv
// qbus_slave
//   Q-bus (MPI) target for the K1801VM2 CPU core. Watches SYNC/DIN/DOUT/WTBT
//   on the multiplexed AD bus and claims cycles whose address falls inside
//   the BASE/MASK window. It generates RPLY and turns each claimed cycle into
//   one request/acknowledge transaction on a simple internal memory port.
//
//   Build option: define QSLV_RMW_EN to support DATIO/DATIOB, where a read
//   and then a write happen under a single SYNC.
//
//   Ports
//     clk, rst_n        system clock, synchronous active-low reset
//     init              bus INIT, synchronised, same effect as reset
//     sync, din, dout   bus strobes
//     wtbt              address phase: write cycle; data phase: byte transfer
//     iako              interrupt acknowledge, never claimed
//     ad_in             AD bus as seen from the bus
//     ad_out, ad_oe     read data and its output enable (tristate built above)
//     rply              bus reply
//     mem_addr          latched word address (AD bits 15:1)
//     mem_be            byte enables, bit 0 = low byte
//     mem_wdata         write data
//     mem_rd, mem_wr    level requests, held until mem_ack
//     mem_rdata         read data, valid with mem_ack
//     mem_ack           single-cycle completion strobe
//
//   State      | meaning
//   -----------+---------------------------------------------------------
//   IDLE       | waiting for the rising edge of SYNC
//   ADDR       | address claimed, waiting for DIN or DOUT
//   RD_REQ     | mem_rd raised, waiting for mem_ack
//   RD_REPLY   | read data on AD, rply held until DIN drops
//   RMW_CHK    | read finished; decide between a write phase and end
//   WR_REQ     | mem_wr raised, waiting for mem_ack
//   WR_REPLY   | rply held until DOUT drops
//   WAIT_END   | cycle not ours or finished; wait for SYNC to drop

module qbus_slave #(
  parameter logic [15:0] BASE        = 16'o160000,
  parameter logic [15:0] MASK        = 16'o170000,
  parameter int          SYNC_STAGES = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        init,
  input  logic        sync,
  input  logic        din,
  input  logic        dout,
  input  logic        wtbt,
  input  logic        iako,
  input  logic [15:0] ad_in,
  output logic [15:0] ad_out,
  output logic        ad_oe,
  output logic        rply,
  output logic [14:0] mem_addr,
  output logic [1:0]  mem_be,
  output logic [15:0] mem_wdata,
  output logic        mem_rd,
  output logic        mem_wr,
  input  logic [15:0] mem_rdata,
  input  logic        mem_ack
);

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_ADDR     = 3'd1,
    S_RD_REQ   = 3'd2,
    S_RD_REPLY = 3'd3,
    S_RMW_CHK  = 3'd4,
    S_WR_REQ   = 3'd5,
    S_WR_REPLY = 3'd6,
    S_WAIT_END = 3'd7
  } state_t;

  // Synchroniser: bit order {init, iako, wtbt, dout, din, sync}
  logic [5:0]                   bus_raw;
  logic [SYNC_STAGES-1:0][5:0]  sync_pipe;
  logic                         sync_s, din_s, dout_s, wtbt_s, iako_s, init_s;
  logic                         sync_q;

  assign bus_raw = {init, iako, wtbt, dout, din, sync};
  assign {init_s, iako_s, wtbt_s, dout_s, din_s, sync_s} = sync_pipe[SYNC_STAGES-1];

  // sync_q is only cleared by rst_n so that INIT does not fake a SYNC edge
  // while the CPU still holds SYNC high.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync_pipe <= '0;
      sync_q    <= 1'b0;
    end else begin
      sync_pipe[0] <= bus_raw;
      for (int i = 1; i < SYNC_STAGES; i++) begin
        sync_pipe[i] <= sync_pipe[i-1];
      end
      sync_q <= sync_s;
    end
  end

  state_t      state, state_n;
  logic        a0, a0_n;
  logic        rd_done, rd_done_n;
  logic [15:0] ad_out_n;
  logic        ad_oe_n, rply_n;
  logic [14:0] mem_addr_n;
  logic [1:0]  mem_be_n;
  logic [15:0] mem_wdata_n;
  logic        mem_rd_n, mem_wr_n;
  logic        in_window;

  assign in_window = ((ad_in & MASK) == BASE);

  always_ff @(posedge clk) begin
    if (!rst_n || init_s) begin
      state     <= S_IDLE;
      a0        <= 1'b0;
      rd_done   <= 1'b0;
      ad_out    <= '0;
      ad_oe     <= 1'b0;
      rply      <= 1'b0;
      mem_addr  <= '0;
      mem_be    <= '0;
      mem_wdata <= '0;
      mem_rd    <= 1'b0;
      mem_wr    <= 1'b0;
    end else begin
      state     <= state_n;
      a0        <= a0_n;
      rd_done   <= rd_done_n;
      ad_out    <= ad_out_n;
      ad_oe     <= ad_oe_n;
      rply      <= rply_n;
      mem_addr  <= mem_addr_n;
      mem_be    <= mem_be_n;
      mem_wdata <= mem_wdata_n;
      mem_rd    <= mem_rd_n;
      mem_wr    <= mem_wr_n;
    end
  end

  always_comb begin
    state_n     = state;
    a0_n        = a0;
    rd_done_n   = rd_done;
    ad_out_n    = ad_out;
    ad_oe_n     = ad_oe;
    rply_n      = rply;
    mem_addr_n  = mem_addr;
    mem_be_n    = mem_be;
    mem_wdata_n = mem_wdata;
    mem_rd_n    = mem_rd;
    mem_wr_n    = mem_wr;

    unique case (state)
      S_IDLE: begin
        if (sync_s && !sync_q) begin
          if (iako_s || !in_window) begin
            state_n = S_WAIT_END;
          end else begin
            state_n    = S_ADDR;
            mem_addr_n = ad_in[15:1];
            a0_n       = ad_in[0];
            rd_done_n  = 1'b0;
          end
        end
      end

      S_ADDR: begin
        // rd_done keeps a DATIO cycle from performing a second read.
        if (din_s && !rd_done) begin
          state_n  = S_RD_REQ;
          mem_rd_n = 1'b1;
          mem_be_n = 2'b11;
        end else if (dout_s) begin
          state_n     = S_WR_REQ;
          mem_wr_n    = 1'b1;
          mem_wdata_n = ad_in;
          if (wtbt_s) begin
            mem_be_n = a0 ? 2'b10 : 2'b01;
          end else begin
            mem_be_n = 2'b11;
          end
        end
      end

      S_RD_REQ: begin
        // A strobe withdrawn before the ack would leave rply asserted with
        // neither DIN nor DOUT active, so the request is dropped instead.
        if (!din_s) begin
          state_n  = S_WAIT_END;
          mem_rd_n = 1'b0;
        end else if (mem_ack) begin
          state_n   = S_RD_REPLY;
          ad_out_n  = mem_rdata;
          ad_oe_n   = 1'b1;
          rply_n    = 1'b1;
          mem_rd_n  = 1'b0;
          rd_done_n = 1'b1;
        end
      end

      S_RD_REPLY: begin
        if (!din_s) begin
          state_n = S_RMW_CHK;
          rply_n  = 1'b0;
          ad_oe_n = 1'b0;
        end
      end

      S_RMW_CHK: begin
`ifdef QSLV_RMW_EN
        state_n = S_ADDR;
`else
        state_n = S_WAIT_END;
`endif
      end

      S_WR_REQ: begin
        if (!dout_s) begin
          state_n  = S_WAIT_END;
          mem_wr_n = 1'b0;
        end else if (mem_ack) begin
          state_n  = S_WR_REPLY;
          rply_n   = 1'b1;
          mem_wr_n = 1'b0;
        end
      end

      S_WR_REPLY: begin
        if (!dout_s) begin
          state_n = S_WAIT_END;
          rply_n  = 1'b0;
        end
      end

      S_WAIT_END: begin
        if (!sync_s) begin
          state_n = S_IDLE;
        end
      end

      default: begin
        state_n = S_IDLE;
      end
    endcase

    // SYNC falling ends the cycle from any state; a late mem_ack then finds
    // the FSM outside the request states and is ignored.
    if (state != S_IDLE && !sync_s) begin
      state_n  = S_IDLE;
      rply_n   = 1'b0;
      ad_oe_n  = 1'b0;
      mem_rd_n = 1'b0;
      mem_wr_n = 1'b0;
    end
  end

endmodule

// File: tb/tb_qbus_slave.sv
module tb_qbus_slave;

  localparam logic [15:0] BASE = 16'o160000;
  localparam logic [15:0] MASK = 16'o170000;
  localparam int          SS   = 2;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0, init = 1'b0;
  logic        sync = 1'b0, din = 1'b0, dout = 1'b0, wtbt = 1'b0, iako = 1'b0;
  logic [15:0] ad_in = '0;
  logic [15:0] ad_out;
  logic        ad_oe, rply;
  logic [14:0] mem_addr;
  logic [1:0]  mem_be;
  logic [15:0] mem_wdata;
  logic        mem_rd, mem_wr;
  logic [15:0] mem_rdata = '0;
  logic        mem_ack = 1'b0;

  qbus_slave #(.BASE(BASE), .MASK(MASK), .SYNC_STAGES(SS)) dut (
    .clk(clk), .rst_n(rst_n), .init(init), .sync(sync), .din(din), .dout(dout),
    .wtbt(wtbt), .iako(iako), .ad_in(ad_in), .ad_out(ad_out), .ad_oe(ad_oe),
    .rply(rply), .mem_addr(mem_addr), .mem_be(mem_be), .mem_wdata(mem_wdata),
    .mem_rd(mem_rd), .mem_wr(mem_wr), .mem_rdata(mem_rdata), .mem_ack(mem_ack)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  // Memory-side responder: acks after ack_delay cycles of request and logs
  // what the request looked like at that moment.
  typedef struct {
    bit          wr;
    logic [14:0] addr;
    logic [1:0]  be;
    logic [15:0] wdata;
    int          cycles;
  } req_t;

  req_t        log_q[$];
  bit          ack_en = 1'b1;
  int          ack_delay = 1;
  logic [15:0] rd_value = '0;
  int          req_cnt = 0;

  initial begin
    forever begin
      @(negedge clk);
      if (ack_en) begin
        if ((mem_rd || mem_wr) && !mem_ack) begin
          req_cnt++;
          if (req_cnt >= ack_delay) begin
            mem_ack   = 1'b1;
            mem_rdata = rd_value;
            log_q.push_back(req_t'{mem_wr, mem_addr, mem_be, mem_wdata, req_cnt});
            req_cnt   = 0;
          end
        end else begin
          mem_ack   = 1'b0;
          mem_rdata = 16'($urandom);
          if (!(mem_rd || mem_wr)) req_cnt = 0;
        end
      end
    end
  end

  // Reply-pulse counter and the ad_oe-implies-rply rule.
  int   rply_pulses = 0;
  logic rply_prev = 1'b0;
  initial begin
    forever begin
      @(negedge clk);
      if (rply && !rply_prev) rply_pulses++;
      if (ad_oe) begin
        n_cmp++;
        if (rply !== 1'b1) begin
          n_err++;
          $display("FAIL oe_without_rply: ad_oe=%b rply=%b (rply must be 1)", ad_oe, rply);
        end
      end
      rply_prev = rply;
    end
  end

  // ---------------- bus master primitives ----------------
  task automatic bus_addr(input logic [15:0] a, input logic w, input logic ik);
    @(negedge clk);
    ad_in = a; wtbt = w; iako = ik; sync = 1'b1;
    repeat (SS + 1) @(negedge clk);
    ad_in = 16'($urandom);
  endtask

  task automatic bus_read(output logic [15:0] data, output bit got);
    got = 1'b0; data = '0;
    din = 1'b1; wtbt = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (rply) begin got = 1'b1; break; end
    end
    if (got) begin
      data = ad_out;
      n_cmp++;
      if (ad_oe !== 1'b1) begin
        n_err++; $display("FAIL read_oe: ad_oe=%b expected 1", ad_oe);
      end
      repeat (2) @(negedge clk);
      n_cmp++;
      if ({rply, ad_oe} !== 2'b11 || ad_out !== data) begin
        n_err++;
        $display("FAIL read_hold: rply=%b ad_oe=%b ad_out=%h expected 1 1 %h", rply, ad_oe, ad_out, data);
      end
    end
    din = 1'b0;
    for (int i = 0; i < 10; i++) begin
      if (!rply && !ad_oe) break;
      @(negedge clk);
    end
    n_cmp++;
    if ({rply, ad_oe} !== 2'b00) begin
      n_err++; $display("FAIL read_release: rply=%b ad_oe=%b expected 0 0", rply, ad_oe);
    end
  endtask

  task automatic bus_write(input logic [15:0] d, input logic bt, output bit got);
    got = 1'b0;
    ad_in = d; wtbt = bt; dout = 1'b1;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (rply) begin got = 1'b1; break; end
    end
    if (got) begin
      repeat (2) @(negedge clk);
      n_cmp++;
      if (rply !== 1'b1) begin
        n_err++; $display("FAIL write_hold: rply=%b expected 1", rply);
      end
    end
    dout = 1'b0;
    for (int i = 0; i < 10; i++) begin
      if (!rply) break;
      @(negedge clk);
    end
    n_cmp++;
    if (rply !== 1'b0) begin
      n_err++; $display("FAIL write_release: rply=%b expected 0", rply);
    end
  endtask

  task automatic bus_end();
    sync = 1'b0; din = 1'b0; dout = 1'b0; wtbt = 1'b0; iako = 1'b0;
    repeat (SS + 3) @(negedge clk);
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    n_cmp++;
    if ({ad_out, ad_oe, rply, mem_addr, mem_be, mem_wdata, mem_rd, mem_wr} !== '0) begin
      n_err++;
      $display("FAIL reset_outputs: ad_out=%h ad_oe=%b rply=%b addr=%o be=%b wdata=%h rd=%b wr=%b expected all 0",
               ad_out, ad_oe, rply, mem_addr, mem_be, mem_wdata, mem_rd, mem_wr);
    end
    rst_n = 1'b1;
    repeat (SS + 2) @(negedge clk);
  endtask

  task automatic test_dati();
    logic [15:0] d; bit got; int p0;
    log_q.delete(); p0 = rply_pulses;
    ack_delay = 3; rd_value = 16'h1234;
    bus_addr(16'o160010, 1'b0, 1'b0);
    n_cmp++;
    if (mem_addr !== 15'o70004) begin
      n_err++; $display("FAIL dati_addr: mem_addr=%o expected 70004", mem_addr);
    end
    bus_read(d, got);
    bus_end();
    n_cmp++;
    if (got !== 1'b1 || d !== 16'h1234) begin
      n_err++; $display("FAIL dati_data: got=%b ad_out=%h expected 1 1234", got, d);
    end
    n_cmp++;
    if (log_q.size() != 1) begin
      n_err++; $display("FAIL dati_reqs: requests=%0d expected 1", log_q.size());
    end else begin
      n_cmp++;
      if (log_q[0].wr !== 1'b0 || log_q[0].be !== 2'b11 || log_q[0].cycles != 3) begin
        n_err++;
        $display("FAIL dati_req: wr=%b be=%b rd_cycles=%0d expected 0 11 3", log_q[0].wr, log_q[0].be, log_q[0].cycles);
      end
    end
    n_cmp++;
    if (rply_pulses - p0 != 1) begin
      n_err++; $display("FAIL dati_pulses: pulses=%0d expected 1", rply_pulses - p0);
    end
  endtask

  task automatic test_datob();
    bit got;
    log_q.delete();
    ack_delay = 2;
    bus_addr(16'o160003, 1'b1, 1'b0);
    bus_write(16'hAB00, 1'b1, got);
    bus_end();
    n_cmp++;
    if (got !== 1'b1) begin
      n_err++; $display("FAIL datob_rply: got=%b expected 1", got);
    end
    n_cmp++;
    if (log_q.size() != 1) begin
      n_err++; $display("FAIL datob_reqs: requests=%0d expected 1", log_q.size());
    end else begin
      n_cmp++;
      if (log_q[0].wr !== 1'b1 || log_q[0].be !== 2'b10 || log_q[0].wdata[15:8] !== 8'hAB || log_q[0].addr !== 15'o70001) begin
        n_err++;
        $display("FAIL datob_req: wr=%b be=%b wdata_hi=%h addr=%o expected 1 10 ab 70001",
                 log_q[0].wr, log_q[0].be, log_q[0].wdata[15:8], log_q[0].addr);
      end
    end
  endtask

  task automatic test_unclaimed();
    logic [15:0] d; bit got; int p0;
    // out of window
    log_q.delete(); p0 = rply_pulses;
    bus_addr(16'o140000, 1'b0, 1'b0);
    bus_read(d, got);
    bus_end();
    n_cmp++;
    if (got !== 1'b0 || log_q.size() != 0 || rply_pulses != p0) begin
      n_err++;
      $display("FAIL out_of_window: got=%b requests=%0d pulses=%0d expected 0 0 0", got, log_q.size(), rply_pulses - p0);
    end
    // in window but interrupt acknowledge
    log_q.delete(); p0 = rply_pulses;
    bus_addr(16'o160010, 1'b0, 1'b1);
    bus_read(d, got);
    bus_end();
    n_cmp++;
    if (got !== 1'b0 || log_q.size() != 0 || rply_pulses != p0) begin
      n_err++;
      $display("FAIL iako: got=%b requests=%0d pulses=%0d expected 0 0 0", got, log_q.size(), rply_pulses - p0);
    end
  endtask

  task automatic test_abort();
    logic [15:0] d; bit got, seen; int p0;
    ack_en = 1'b0;
    log_q.delete(); p0 = rply_pulses;
    bus_addr(16'o160100, 1'b0, 1'b0);
    din = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (mem_rd) begin seen = 1'b1; break; end
    end
    n_cmp++;
    if (!seen) begin
      n_err++; $display("FAIL abort_rd_start: mem_rd=%b expected 1 within 20 clocks", mem_rd);
    end
    sync = 1'b0;
    repeat (SS) @(negedge clk);
    n_cmp++;
    if (mem_rd !== 1'b1) begin
      n_err++; $display("FAIL abort_sync_delay: mem_rd=%b expected 1", mem_rd);
    end
    @(negedge clk);
    n_cmp++;
    if ({mem_rd, mem_wr, rply, ad_oe} !== 4'b0000) begin
      n_err++; $display("FAIL abort_drop: rd=%b wr=%b rply=%b oe=%b expected 0 0 0 0", mem_rd, mem_wr, rply, ad_oe);
    end
    din = 1'b0;
    repeat (2) @(negedge clk);
    mem_ack = 1'b1; mem_rdata = 16'hBEEF;
    @(negedge clk);
    mem_ack = 1'b0;
    repeat (6) @(negedge clk);
    n_cmp++;
    if (rply_pulses != p0 || rply !== 1'b0) begin
      n_err++; $display("FAIL abort_late_ack: pulses=%0d rply=%b expected 0 0", rply_pulses - p0, rply);
    end
    ack_en = 1'b1;
    ack_delay = 1; rd_value = 16'hC0DE;
    log_q.delete();
    bus_addr(16'o160102, 1'b0, 1'b0);
    bus_read(d, got);
    bus_end();
    n_cmp++;
    if (got !== 1'b1 || d !== 16'hC0DE || log_q.size() != 1) begin
      n_err++; $display("FAIL abort_recover: got=%b data=%h requests=%0d expected 1 c0de 1", got, d, log_q.size());
    end
  endtask

  task automatic test_rmw();
    logic [15:0] d; bit got_r, got_w; int p0;
    log_q.delete(); p0 = rply_pulses;
    ack_delay = 2; rd_value = 16'h0F0F;
    bus_addr(16'o160020, 1'b0, 1'b0);
    bus_read(d, got_r);
    bus_write(16'h5A5A, 1'b0, got_w);
`ifdef QSLV_RMW_EN
    begin
      logic [15:0] d2; bit got2;
      bus_read(d2, got2);
      n_cmp++;
      if (got2 !== 1'b0) begin
        n_err++; $display("FAIL rmw_second_read: got=%b expected 0", got2);
      end
    end
`endif
    bus_end();
    n_cmp++;
    if (got_r !== 1'b1 || d !== 16'h0F0F) begin
      n_err++; $display("FAIL rmw_read: got=%b data=%h expected 1 0f0f", got_r, d);
    end
`ifdef QSLV_RMW_EN
    n_cmp++;
    if (got_w !== 1'b1 || rply_pulses - p0 != 2 || log_q.size() != 2) begin
      n_err++;
      $display("FAIL rmw_write: got=%b pulses=%0d requests=%0d expected 1 2 2", got_w, rply_pulses - p0, log_q.size());
    end else begin
      n_cmp++;
      if (log_q[0].wr !== 1'b0 || log_q[1].wr !== 1'b1 || log_q[0].addr !== 15'o70010 ||
          log_q[1].addr !== 15'o70010 || log_q[1].wdata !== 16'h5A5A || log_q[1].be !== 2'b11) begin
        n_err++;
        $display("FAIL rmw_reqs: wr0=%b wr1=%b addr0=%o addr1=%o wdata=%h be=%b expected 0 1 70010 70010 5a5a 11",
                 log_q[0].wr, log_q[1].wr, log_q[0].addr, log_q[1].addr, log_q[1].wdata, log_q[1].be);
      end
    end
`else
    n_cmp++;
    if (got_w !== 1'b0 || rply_pulses - p0 != 1 || log_q.size() != 1) begin
      n_err++;
      $display("FAIL rmw_disabled: got=%b pulses=%0d requests=%0d expected 0 1 1", got_w, rply_pulses - p0, log_q.size());
    end
`endif
  endtask

  task automatic start_read_to_reply(input logic [15:0] a, output bit got);
    got = 1'b0;
    ack_delay = 2; rd_value = 16'h7777;
    bus_addr(a, 1'b0, 1'b0);
    din = 1'b1;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (rply) begin got = 1'b1; break; end
    end
  endtask

  task automatic test_reset_mid();
    bit got;
    start_read_to_reply(16'o160040, got);
    n_cmp++;
    if (got !== 1'b1) begin
      n_err++; $display("FAIL rst_mid_setup: rply=%b expected 1", rply);
    end
    rst_n = 1'b0;
    @(negedge clk);
    n_cmp++;
    if ({ad_out, ad_oe, rply, mem_addr, mem_be, mem_wdata, mem_rd, mem_wr} !== '0) begin
      n_err++;
      $display("FAIL rst_mid: ad_out=%h oe=%b rply=%b addr=%o be=%b wdata=%h rd=%b wr=%b expected all 0",
               ad_out, ad_oe, rply, mem_addr, mem_be, mem_wdata, mem_rd, mem_wr);
    end
    din = 1'b0; sync = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (SS + 2) @(negedge clk);

    start_read_to_reply(16'o160042, got);
    n_cmp++;
    if (got !== 1'b1) begin
      n_err++; $display("FAIL init_mid_setup: rply=%b expected 1", rply);
    end
    init = 1'b1;
    repeat (SS) @(negedge clk);
    n_cmp++;
    if (rply !== 1'b1) begin
      n_err++; $display("FAIL init_sync_delay: rply=%b expected 1", rply);
    end
    @(negedge clk);
    n_cmp++;
    if ({ad_out, ad_oe, rply, mem_addr, mem_be, mem_wdata, mem_rd, mem_wr} !== '0) begin
      n_err++;
      $display("FAIL init_mid: ad_out=%h oe=%b rply=%b addr=%o be=%b wdata=%h rd=%b wr=%b expected all 0",
               ad_out, ad_oe, rply, mem_addr, mem_be, mem_wdata, mem_rd, mem_wr);
    end
    din = 1'b0; sync = 1'b0;
    repeat (SS + 3) @(negedge clk);
    init = 1'b0;
    repeat (SS + 3) @(negedge clk);
  endtask

  task automatic test_random();
    logic [15:0] a, d, rdat, mask;
    logic [1:0]  exp_be;
    logic        ik, is_wr, bt;
    bit          got, claim;
    int          p0;
    for (int n = 0; n < 40; n++) begin
      a = 16'($urandom);
      if ($urandom_range(0, 2) != 0) a = (a & ~MASK) | BASE;
      ik    = ($urandom_range(0, 9) == 0);
      is_wr = 1'($urandom_range(0, 1));
      bt    = is_wr ? 1'($urandom_range(0, 1)) : 1'b0;
      d     = 16'($urandom);
      ack_delay = $urandom_range(1, 5);
      rd_value  = 16'($urandom);
      claim  = ((a & MASK) == BASE) && !ik;
      exp_be = (!is_wr || !bt) ? 2'b11 : (a[0] ? 2'b10 : 2'b01);
      mask   = {{8{exp_be[1]}}, {8{exp_be[0]}}};
      log_q.delete(); p0 = rply_pulses;
      bus_addr(a, is_wr, ik);
      if (is_wr) bus_write(d, bt, got);
      else       bus_read(rdat, got);
      bus_end();
      n_cmp++;
      if (got !== claim || rply_pulses - p0 != int'(claim) || log_q.size() != int'(claim)) begin
        n_err++;
        $display("FAIL rand_claim[%0d]: a=%o got=%b pulses=%0d requests=%0d expected %b %0d %0d",
                 n, a, got, rply_pulses - p0, log_q.size(), claim, int'(claim), int'(claim));
      end else if (claim) begin
        n_cmp++;
        if (log_q[0].wr !== is_wr || log_q[0].addr !== a[15:1] || log_q[0].be !== exp_be ||
            log_q[0].cycles != ack_delay) begin
          n_err++;
          $display("FAIL rand_req[%0d]: wr=%b addr=%o be=%b cycles=%0d expected %b %o %b %0d",
                   n, log_q[0].wr, log_q[0].addr, log_q[0].be, log_q[0].cycles, is_wr, a[15:1], exp_be, ack_delay);
        end
        n_cmp++;
        if (is_wr ? ((log_q[0].wdata & mask) !== (d & mask)) : (rdat !== rd_value)) begin
          n_err++;
          $display("FAIL rand_data[%0d]: wdata=%h rdata=%h expected wdata %h (mask %h) or rdata %h",
                   n, log_q[0].wdata, rdat, d, mask, rd_value);
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_dati();
    test_datob();
    test_unclaimed();
    test_abort();
    test_rmw();
    test_reset_mid();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
